// File: rtl/id_stage.sv
// ============================================================================
// Module   : id_stage
// Purpose  : MIPS decode stage: IF/ID register, 32x32 GRF, forwarding muxes,
//            beq/j/jal/jr next-PC decode. Optional macro: ID_WBYPASS_EN
//            (write-through bypass on GRF reads).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic        stall,
  input  logic [1:0]  fwd_rs_sel,
  input  logic [1:0]  fwd_rt_sel,
  input  logic [31:0] fwd_e_data,
  input  logic [31:0] fwd_m_data,
  input  logic        we_w,
  input  logic [4:0]  waddr_w,
  input  logic [31:0] wdata_w,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [1:0]  npc_sel,
  output logic        br_e,
  output logic [15:0] imm16,
  output logic [25:0] imm26,
  output logic [31:0] jr_pc
);

  localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
  localparam logic [5:0] c_OP_BEQ     = 6'b000100;
  localparam logic [5:0] c_OP_J       = 6'b000010;
  localparam logic [5:0] c_OP_JAL     = 6'b000011;
  localparam logic [5:0] c_FN_JR      = 6'b001000;

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_grf [0:31];

  logic [4:0]  w_rs_addr;
  logic [4:0]  w_rt_addr;
  logic [31:0] w_rs_grf;
  logic [31:0] w_rt_grf;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_grf_we;

  // IF/ID pipeline register; reset takes priority over stall
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= RESET_PC;
    end else if (!stall) begin
      r_instr <= instr_f;
      r_pc    <= pc_f;
    end
  end

  assign w_grf_we = we_w && (waddr_w != 5'd0);

  // Register file: entry 0 is never written so it stays zero after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_grf[i] <= '0;
      end
    end else if (w_grf_we) begin
      r_grf[waddr_w] <= wdata_w;
    end
  end

  assign w_rs_addr = r_instr[25:21];
  assign w_rt_addr = r_instr[20:16];
  assign w_op      = r_instr[31:26];
  assign w_funct   = r_instr[5:0];

`ifdef ID_WBYPASS_EN
  // Write-through: a same-cycle WB write is seen by the read before the edge
  assign w_rs_grf = (w_grf_we && (waddr_w == w_rs_addr)) ? wdata_w : r_grf[w_rs_addr];
  assign w_rt_grf = (w_grf_we && (waddr_w == w_rt_addr)) ? wdata_w : r_grf[w_rt_addr];
`else
  assign w_rs_grf = r_grf[w_rs_addr];
  assign w_rt_grf = r_grf[w_rt_addr];
`endif

  // Register $0 reads as zero no matter what the forwarding select says
  always_comb begin
    rs_data = w_rs_grf;
    if (w_rs_addr == 5'd0) begin
      rs_data = '0;
    end else begin
      case (fwd_rs_sel)
        2'd1:    rs_data = fwd_e_data;
        2'd2:    rs_data = fwd_m_data;
        default: rs_data = w_rs_grf;
      endcase
    end
  end

  always_comb begin
    rt_data = w_rt_grf;
    if (w_rt_addr == 5'd0) begin
      rt_data = '0;
    end else begin
      case (fwd_rt_sel)
        2'd1:    rt_data = fwd_e_data;
        2'd2:    rt_data = fwd_m_data;
        default: rt_data = w_rt_grf;
      endcase
    end
  end

  always_comb begin
    npc_sel = 2'b00;
    case (w_op)
      c_OP_BEQ:         npc_sel = 2'b01;
      c_OP_J, c_OP_JAL: npc_sel = 2'b10;
      c_OP_SPECIAL:     npc_sel = (w_funct == c_FN_JR) ? 2'b11 : 2'b00;
      default:          npc_sel = 2'b00;
    endcase
  end

  assign instr_d = r_instr;
  assign pc_d    = r_pc;
  assign pc8_d   = r_pc + 32'd8;
  assign br_e    = (rs_data == rt_data);
  assign imm16   = r_instr[15:0];
  assign imm26   = r_instr[25:0];
  assign jr_pc   = rs_data;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Scoreboard-driven self-checking bench for id_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_f, pc_f;
  logic        stall;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] fwd_e_data, fwd_m_data;
  logic        we_w;
  logic [4:0]  waddr_w;
  logic [31:0] wdata_w;
  logic [31:0] instr_d, pc_d, pc8_d, rs_data, rt_data, jr_pc;
  logic [1:0]  npc_sel;
  logic        br_e;
  logic [15:0] imm16;
  logic [25:0] imm26;

  always #5 clk = ~clk;

  id_stage #(.RESET_PC(32'h00003000)) dut (
    .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .fwd_e_data(fwd_e_data), .fwd_m_data(fwd_m_data),
    .we_w(we_w), .waddr_w(waddr_w), .wdata_w(wdata_w),
    .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d),
    .rs_data(rs_data), .rt_data(rt_data), .npc_sel(npc_sel), .br_e(br_e),
    .imm16(imm16), .imm26(imm26), .jr_pc(jr_pc)
  );

  localparam int c_S_INSTR = 0, c_S_PC = 1, c_S_PC8 = 2, c_S_RS = 3, c_S_RT = 4,
                 c_S_NPC = 5, c_S_BRE = 6, c_S_I16 = 7, c_S_I26 = 8, c_S_JR = 9;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      c_S_INSTR: return instr_d;
      c_S_PC:    return pc_d;
      c_S_PC8:   return pc8_d;
      c_S_RS:    return rs_data;
      c_S_RT:    return rt_data;
      c_S_NPC:   return {30'd0, npc_sel};
      c_S_BRE:   return {31'd0, br_e};
      c_S_I16:   return {16'd0, imm16};
      c_S_I26:   return {6'd0, imm26};
      default:   return jr_pc;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sig = sig; e.exp = exp;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then pop and compare every pending entry
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_w = 1'b1; waddr_w = a; wdata_w = d;
    step();
    we_w = 1'b0;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc);
    instr_f = ins; pc_f = pc;
    step();
  endtask

  initial begin
    reset = 1'b1; instr_f = '0; pc_f = '0; stall = 1'b0;
    fwd_rs_sel = 2'd0; fwd_rt_sel = 2'd0; fwd_e_data = '0; fwd_m_data = '0;
    we_w = 1'b0; waddr_w = '0; wdata_w = '0;
    step(); step();
    reset = 1'b0;
    push("rst_instr", c_S_INSTR, 32'h0);
    push("rst_pc",    c_S_PC,    32'h3000);
    push("rst_pc8",   c_S_PC8,   32'h3008);
    push("rst_rs",    c_S_RS,    32'h0);
    push("rst_rt",    c_S_RT,    32'h0);
    push("rst_npc",   c_S_NPC,   32'd0);
    push("rst_bre",   c_S_BRE,   32'd1);
    push("rst_i16",   c_S_I16,   32'h0);
    push("rst_i26",   c_S_I26,   32'h0);
    push("rst_jr",    c_S_JR,    32'h0);
    drain();

    load(32'h3c011234, 32'h3000);
    push("lui_instr", c_S_INSTR, 32'h3c011234);
    push("lui_pc",    c_S_PC,    32'h3000);
    push("lui_pc8",   c_S_PC8,   32'h3008);
    push("lui_npc",   c_S_NPC,   32'd0);
    drain();

    wr(5'd1, 32'd5);
    wr(5'd2, 32'd5);
    load(32'h10220003, 32'h3004);
    push("beq_npc", c_S_NPC, 32'd1);
    push("beq_bre", c_S_BRE, 32'd1);
    push("beq_i16", c_S_I16, 32'h0003);
    push("beq_rs",  c_S_RS,  32'd5);
    drain();
    wr(5'd2, 32'd6);
    push("beq_ne_bre", c_S_BRE, 32'd0);
    push("beq_ne_npc", c_S_NPC, 32'd1);
    drain();

    load(32'h0c000c10, 32'h3008);
    push("jal_npc", c_S_NPC, 32'd2);
    push("jal_i26", c_S_I26, 32'h0000c10);
    push("jal_pc8", c_S_PC8, 32'h3010);
    drain();
    wr(5'd31, 32'h3010);
    load(32'h03e00008, 32'h300c);
    push("jr_npc", c_S_NPC, 32'd3);
    push("jr_pc",  c_S_JR,  32'h3010);
    drain();

    // add $4,$3,$2: SPECIAL with a non-jr funct decodes as sequential
    load(32'h00622020, 32'h3010);
    push("add_npc", c_S_NPC, 32'd0);
    push("add_rs",  c_S_RS,  32'd0);
    push("add_rt",  c_S_RT,  32'd6);
    drain();

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_f = $urandom; pc_f = 32'h4000 + 32'(i * 4);
      if (i == 0) wr(5'd3, 32'd77); else step();
      push("stall_instr", c_S_INSTR, 32'h00622020);
      push("stall_pc",    c_S_PC,    32'h3010);
      push("stall_rs3",   c_S_RS,    32'd77);
      drain();
    end
    fwd_rt_sel = 2'd2; fwd_m_data = 32'd7;
    push("stall_fwd_rt", c_S_RT, 32'd7);
    drain();
    fwd_rt_sel = 2'd3;
    push("sel3_grf_rt", c_S_RT, 32'd6);
    drain();
    stall = 1'b0; fwd_rt_sel = 2'd0;

    wr(5'd0, 32'hffffffff);
    load(32'h00042020, 32'h3014);
    fwd_rs_sel = 2'd2; fwd_m_data = 32'd7;
    fwd_rt_sel = 2'd1; fwd_e_data = 32'd9;
    push("r0_fwd_rs", c_S_RS, 32'd0);
    push("r4_fwd_rt", c_S_RT, 32'd9);
    drain();
    load(32'h00800008, 32'h3018);
    fwd_rs_sel = 2'd1; fwd_rt_sel = 2'd0;
    push("r4_fwd_rs", c_S_RS,  32'd9);
    push("r4_fwd_jr", c_S_JR,  32'd9);
    push("r4_bre",    c_S_BRE, 32'd0);
    drain();
    fwd_rs_sel = 2'd0;

    load(32'h00a00008, 32'h301c);
    push("r5_old", c_S_RS, 32'd0);
    drain();
    we_w = 1'b1; waddr_w = 5'd5; wdata_w = 32'hdead;
`ifdef ID_WBYPASS_EN
    push("r5_same_cycle", c_S_RS, 32'hdead);
`else
    push("r5_same_cycle", c_S_RS, 32'h0);
`endif
    drain();
    step();
    we_w = 1'b0;
    push("r5_after", c_S_RS, 32'hdead);
    drain();

    // Reset during stall with a concurrent write: everything cleared, write lost
    stall = 1'b1; reset = 1'b1;
    we_w = 1'b1; waddr_w = 5'd6; wdata_w = 32'h1234;
    step();
    reset = 1'b0; stall = 1'b0; we_w = 1'b0;
    push("rst2_instr", c_S_INSTR, 32'h0);
    push("rst2_pc",    c_S_PC,    32'h3000);
    drain();
    load(32'h00c50000, 32'hfffffffc);
    push("rst2_r6",   c_S_RS,  32'h0);
    push("rst2_r5",   c_S_RT,  32'h0);
    push("rst2_bre",  c_S_BRE, 32'd1);
    push("pc8_wrap",  c_S_PC8, 32'h00000004);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
